// File: rtl/matrix_load_sequencer.sv
// Frame parser for the serial link: HEADER, N, N*N matrix bytes, N vector bytes, TRAILER.
// Pushes payload into the matrix/vector FIFOs, then launches the processors and waits for completion.
module matrix_load_sequencer #(
    parameter logic [7:0]  HEADER  = 8'hFE,
    parameter logic [7:0]  TRAILER = 8'hEF,
    parameter int unsigned MAX_N   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       proc_done,
    output logic       rx_ready,
    output logic [3:0] N,
    output logic       push_matrix,
    output logic       push_vector,
    output logic [7:0] fifo_data,
    output logic       clr_fifos,
    output logic       start,
    output logic       frame_error
);

    localparam int unsigned CNT_W = 7;
    localparam logic [7:0]  MAX_N_B = 8'(MAX_N);

    typedef enum logic [2:0] {
        IDLE,
        GET_N,
        LOAD_MAT,
        LOAD_VEC,
        CHECK_END,
        ISSUE,
        WAIT_DONE
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [3:0]         n_d;
    logic [7:0]         data_d;
    logic               push_m_d, push_v_d, clr_d, start_d, err_d, ready_d;
    logic               accept;
    logic [CNT_W-1:0]   nn;

    // rx_ready is a registered decode of the current state, so it is the handshake qualifier
    assign accept = rx_valid && rx_ready;
    assign nn     = CNT_W'(N) * CNT_W'(N);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            N           <= '0;
            fifo_data   <= '0;
            push_matrix <= 1'b0;
            push_vector <= 1'b0;
            clr_fifos   <= 1'b0;
            start       <= 1'b0;
            frame_error <= 1'b0;
            rx_ready    <= 1'b1;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            N           <= n_d;
            fifo_data   <= data_d;
            push_matrix <= push_m_d;
            push_vector <= push_v_d;
            clr_fifos   <= clr_d;
            start       <= start_d;
            frame_error <= err_d;
            rx_ready    <= ready_d;
        end
    end

    // Next-state and next-output logic; strobes land one cycle after the consuming edge
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        n_d      = N;
        data_d   = fifo_data;
        push_m_d = 1'b0;
        push_v_d = 1'b0;
        clr_d    = 1'b0;
        start_d  = 1'b0;
        err_d    = 1'b0;

        case (state)
            IDLE: begin
                if (accept && rx_data == HEADER) begin
                    state_d = GET_N;
                    clr_d   = 1'b1;
                end
            end
            GET_N: begin
                if (accept) begin
                    if (rx_data >= 8'd1 && rx_data <= MAX_N_B) begin
                        n_d     = rx_data[3:0];
                        cnt_d   = '0;
                        state_d = LOAD_MAT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            LOAD_MAT: begin
                if (accept) begin
                    push_m_d = 1'b1;
                    data_d   = rx_data;
                    if (cnt == nn - CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = LOAD_VEC;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
            end
            LOAD_VEC: begin
                if (accept) begin
                    push_v_d = 1'b1;
                    data_d   = rx_data;
                    if (cnt == CNT_W'(N) - CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = CHECK_END;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
            end
            CHECK_END: begin
                if (accept) begin
                    if (rx_data == TRAILER) begin
                        start_d = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        err_d   = 1'b1;
                        clr_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (proc_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = !(state_d == ISSUE || state_d == WAIT_DONE);
    end

endmodule

// File: tb/tb_matrix_load_sequencer.sv
// Directed bench for matrix_load_sequencer: frames are streamed byte by byte and
// a negedge monitor collects pushes and pulse counts for comparison with hand-computed values.
module tb_matrix_load_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       proc_done;
    logic       rx_ready;
    logic [3:0] N;
    logic       push_matrix;
    logic       push_vector;
    logic [7:0] fifo_data;
    logic       clr_fifos;
    logic       start;
    logic       frame_error;

    int vectors   = 0;
    int miscompares = 0;

    logic [7:0] mq[$];
    logic [7:0] vq[$];
    int n_clr, n_start, n_err, n_clr_err, n_both;

    always #5 clk = ~clk;

    matrix_load_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .proc_done  (proc_done),
        .rx_ready   (rx_ready),
        .N          (N),
        .push_matrix(push_matrix),
        .push_vector(push_vector),
        .fifo_data  (fifo_data),
        .clr_fifos  (clr_fifos),
        .start      (start),
        .frame_error(frame_error)
    );

    always @(negedge clk) begin
        if (push_matrix) mq.push_back(fifo_data);
        if (push_vector) vq.push_back(fifo_data);
        if (clr_fifos) n_clr++;
        if (start) n_start++;
        if (frame_error) n_err++;
        if (clr_fifos && frame_error) n_clr_err++;
        if (push_matrix && push_vector) n_both++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        #1;
        mq.delete();
        vq.delete();
        n_clr = 0; n_start = 0; n_err = 0; n_clr_err = 0; n_both = 0;
    endtask

    // One byte presented for exactly one rising edge; optional idle gap afterwards
    task automatic send(input logic [7:0] b, input bit gap = 1'b0);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        if (gap) begin
            rx_data = 8'hFE;
            @(negedge clk);
        end
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
        #1;
    endtask

    task automatic done_pulse();
        @(negedge clk);
        proc_done = 1'b1;
        @(negedge clk);
        proc_done = 1'b0;
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp_m[$];
        logic [7:0] exp_v[$];

        reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; proc_done = 1'b0;
        clear_log();
        idle(3);
        chk("rst_N", 32'(N), 0);
        chk("rst_strobes", {push_matrix, push_vector, clr_fifos, start, frame_error}, 0);
        chk("rst_data", 32'(fifo_data), 0);
        @(negedge clk);
        reset = 1'b1;
        idle(1);
        chk("rst_ready", 32'(rx_ready), 1);

        // Basic N=2 frame
        clear_log();
        send(8'hFE); send(8'h02);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'h05); send(8'h06);
        send(8'hEF);
        chk("f1_start_now", 32'(start), 1);
        chk("f1_ready_issue", 32'(rx_ready), 0);
        idle(1);
        chk("f1_start_once", 32'(start), 0);
        chk("f1_N", 32'(N), 2);
        send(8'hFE);
        idle(3);
        chk("f1_ready_wait", 32'(rx_ready), 0);
        chk("f1_clr", n_clr, 1);
        chk("f1_mq_n", mq.size(), 4);
        chk("f1_mq", {mq[0], mq[1], mq[2], mq[3]}, 32'h01020304);
        chk("f1_vq_n", vq.size(), 2);
        chk("f1_vq", {vq[0], vq[1]}, 32'h0506);
        chk("f1_start_cnt", n_start, 1);
        chk("f1_err", n_err, 0);
        chk("f1_both", n_both, 0);
        done_pulse();
        chk("f1_ready_idle", 32'(rx_ready), 1);

        // proc_done in IDLE, then stray bytes without header
        clear_log();
        done_pulse();
        send(8'h01); send(8'h02);
        idle(2);
        chk("idle_done_ready", 32'(rx_ready), 1);
        chk("idle_pushes", mq.size() + vq.size(), 0);
        chk("idle_strobes", n_clr + n_start + n_err, 0);

        // Oversize N, then a good N=1 frame
        clear_log();
        send(8'hFE); send(8'h09);
        idle(2);
        chk("f2_err", n_err, 1);
        chk("f2_nopush", mq.size() + vq.size(), 0);
        send(8'hFE); send(8'h01); send(8'h07); send(8'h08); send(8'hEF);
        chk("f2_start_now", 32'(start), 1);
        idle(2);
        chk("f2_N", 32'(N), 1);
        chk("f2_push", {mq.size() == 1, vq.size() == 1, mq[0], vq[0]}, {2'b11, 16'h0708});
        chk("f2_start_cnt", n_start, 1);
        done_pulse();

        // N=0 is rejected
        clear_log();
        send(8'hFE); send(8'h00);
        idle(2);
        chk("n0_err", n_err, 1);
        chk("n0_ready", 32'(rx_ready), 1);

        // Bad trailer
        clear_log();
        send(8'hFE); send(8'h01); send(8'hAA); send(8'hBB); send(8'h00);
        idle(2);
        chk("f3_mq", {mq.size() == 1, mq[0]}, {1'b1, 8'hAA});
        chk("f3_vq", {vq.size() == 1, vq[0]}, {1'b1, 8'hBB});
        chk("f3_err", n_err, 1);
        chk("f3_clr_err", n_clr_err, 1);
        chk("f3_clr", n_clr, 2);
        chk("f3_start", n_start, 0);
        chk("f3_ready", 32'(rx_ready), 1);

        // N=3 with framing bytes inside payload and rx_valid gaps
        clear_log();
        exp_m = '{8'hFE, 8'hEF, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'hFE, 8'hEF};
        exp_v = '{8'h21, 8'hEF, 8'hFE};
        send(8'hFE, 1'b1); send(8'h03, 1'b1);
        foreach (exp_m[i]) send(exp_m[i], 1'b1);
        foreach (exp_v[i]) send(exp_v[i], 1'b1);
        send(8'hEF, 1'b1);
        idle(2);
        chk("f4_mq_n", mq.size(), 9);
        chk("f4_vq_n", vq.size(), 3);
        for (int i = 0; i < 9; i++) chk($sformatf("f4_m%0d", i), 32'(mq[i]), 32'(exp_m[i]));
        for (int i = 0; i < 3; i++) chk($sformatf("f4_v%0d", i), 32'(vq[i]), 32'(exp_v[i]));
        chk("f4_start", n_start, 1);
        chk("f4_N", 32'(N), 3);
        chk("f4_both", n_both, 0);
        done_pulse();

        // Largest dimension: 64 matrix bytes
        clear_log();
        send(8'hFE); send(8'h08);
        for (int i = 0; i < 64; i++) send(8'(i));
        for (int i = 0; i < 8; i++) send(8'(8'h80 + i));
        send(8'hEF);
        idle(2);
        chk("f5_mq_n", mq.size(), 64);
        chk("f5_mq_last", 32'(mq[63]), 32'h3F);
        chk("f5_vq_n", vq.size(), 8);
        chk("f5_vq_last", 32'(vq[7]), 32'h87);
        chk("f5_start", n_start, 1);
        chk("f5_N", 32'(N), 8);
        done_pulse();

        // Reset mid-frame
        clear_log();
        send(8'hFE); send(8'h04);
        for (int i = 0; i < 5; i++) send(8'(8'h30 + i));
        chk("f6_pre_rst_push", 32'(push_matrix), 1);
        reset = 1'b0;
        #1;
        chk("f6_rst_strobes", {push_matrix, push_vector, clr_fifos, start, frame_error}, 0);
        chk("f6_rst_N", 32'(N), 0);
        chk("f6_rst_data", 32'(fifo_data), 0);
        idle(2);
        @(negedge clk);
        reset = 1'b1;
        clear_log();
        for (int i = 0; i < 12; i++) send(8'(8'h40 + i));
        idle(2);
        chk("f6_nopush", mq.size() + vq.size(), 0);
        chk("f6_nostrobe", n_clr + n_start + n_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
